// File: rtl/snake_motion_ctrl.sv
// Snake game-state core: latches direction requests, advances the head on each game tick
// with edge wrap, grows on food, and freezes on self-collision.
module snake_motion_ctrl #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update_clk,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  input  logic [3:0] seg_idx,
  output logic [5:0] seg_x,
  output logic [4:0] seg_y,
  output logic       seg_valid,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       ate,
  output logic       game_over,
  output logic       running
);

  localparam logic [5:0] XMax = 6'(GRID_W - 1);
  localparam logic [4:0] YMax = 5'(GRID_H - 1);
  localparam logic [4:0] LenMax = 5'(MAX_LEN);

  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;
  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e     state_q, state_d;
  dir_e       dir_q, pend_q, req_dir, opp_dir;
  logic [5:0] seg_x_q [MAX_LEN];
  logic [4:0] seg_y_q [MAX_LEN];
  logic [4:0] len_q;
  logic       ate_q;
  logic       req_valid, accept, hit_food, grow, collide, move;
  logic [5:0] nx;
  logic [4:0] ny;
  int         lim;

  // Button priority: up > down > left > right; reversals against the last move are dropped.
  always_comb begin
    req_valid = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        req_dir = DirUp;
    else if (btn_down) req_dir = DirDown;
    else if (btn_left) req_dir = DirLeft;
    else               req_dir = DirRight;
    unique case (dir_q)
      DirUp:   opp_dir = DirDown;
      DirDown: opp_dir = DirUp;
      DirLeft: opp_dir = DirRight;
      default: opp_dir = DirLeft;
    endcase
    accept = req_valid && (req_dir != opp_dir) && (state_q != StDead);
  end

  always_comb begin
    nx = seg_x_q[0];
    ny = seg_y_q[0];
    unique case (pend_q)
      DirUp:    ny = (seg_y_q[0] == 5'd0) ? YMax : seg_y_q[0] - 5'd1;
      DirDown:  ny = (seg_y_q[0] == YMax) ? 5'd0 : seg_y_q[0] + 5'd1;
      DirLeft:  nx = (seg_x_q[0] == 6'd0) ? XMax : seg_x_q[0] - 6'd1;
      default:  nx = (seg_x_q[0] == XMax) ? 6'd0 : seg_x_q[0] + 6'd1;
    endcase
    hit_food = (nx == food_x) && (ny == food_y);
    grow     = hit_food && (len_q < LenMax);
    // On a plain move the tail cell vacates, so it is not a collision candidate.
    lim      = grow ? int'(len_q) : int'(len_q) - 1;
    collide  = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if ((i < lim) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny)) collide = 1'b1;
    end
    move = (state_q == StRun) && update_clk && !collide;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (update_clk && collide) state_d = StDead;
      default: state_d = StDead;
    endcase
  end

  always_comb begin
    running   = (state_q == StRun);
    game_over = (state_q == StDead);
    seg_x     = '0;
    seg_y     = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (seg_idx == 4'(i)) begin
        seg_x = seg_x_q[i];
        seg_y = seg_y_q[i];
      end
    end
    seg_valid = ({1'b0, seg_idx} < len_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= DirRight;
      pend_q <= DirRight;
      len_q  <= 5'(INIT_LEN);
      ate_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= (i < int'(INIT_LEN)) ? 6'(int'(START_X) - i) : 6'd0;
        seg_y_q[i] <= (i < int'(INIT_LEN)) ? 5'(START_Y) : 5'd0;
      end
    end else begin
      if (accept) pend_q <= req_dir;
      ate_q <= move && hit_food;
      if (move) begin
        for (int i = 1; i < int'(MAX_LEN); i++) begin
          seg_x_q[i] <= seg_x_q[i-1];
          seg_y_q[i] <= seg_y_q[i-1];
        end
        seg_x_q[0] <= nx;
        seg_y_q[0] <= ny;
        dir_q      <= pend_q;
        if (grow) len_q <= len_q + 5'd1;
      end
    end
  end

  assign head_x = seg_x_q[0];
  assign head_y = seg_y_q[0];
  assign length = len_q;
  assign ate    = ate_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl at default parameters.
module tb_snake_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update_clk = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [5:0] food_x = 6'd63;
  logic [4:0] food_y = 5'd31;
  logic [3:0] seg_idx = 4'd0;
  logic [5:0] seg_x, head_x;
  logic [4:0] seg_y, head_y, length;
  logic       seg_valid, ate, game_over, running;
  int         total = 0;
  int         bad = 0;

  snake_motion_ctrl dut (
    .clk(clk), .rst(rst), .update_clk(update_clk),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .food_x(food_x), .food_y(food_y), .seg_idx(seg_idx),
    .seg_x(seg_x), .seg_y(seg_y), .seg_valid(seg_valid),
    .head_x(head_x), .head_y(head_y), .length(length),
    .ate(ate), .game_over(game_over), .running(running)
  );

  always #5 clk = ~clk;

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk) set_btn(u, d, l, r);
    @(negedge clk) set_btn(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk) update_clk = 1'b1;
    @(negedge clk) update_clk = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [5:0] ex, input logic [4:0] ey);
    total++;
    if (head_x !== ex || head_y !== ey) begin
      bad++;
      $display("FAIL %s: head=(%0d,%0d) expected (%0d,%0d)", name, head_x, head_y, ex, ey);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({running, game_over, ate, length} !== {3'b000, 5'd3}) begin
      bad++; $display("FAIL reset_flags: run/go/ate/len=%b/%b/%b/%0d expected 0/0/0/3",
                      running, game_over, ate, length);
    end
    chk_head("reset_head", 6'd20, 5'd15);
    seg_idx = 4'd2; #1;
    total++;
    if (seg_x !== 6'd18 || seg_y !== 5'd15 || seg_valid !== 1'b1) begin
      bad++; $display("FAIL reset_seg2: (%0d,%0d,v%b) expected (18,15,v1)", seg_x, seg_y, seg_valid);
    end
    seg_idx = 4'd3; #1;
    total++;
    if (seg_x !== 6'd0 || seg_y !== 5'd0 || seg_valid !== 1'b0) begin
      bad++; $display("FAIL reset_seg3: (%0d,%0d,v%b) expected (0,0,v0)", seg_x, seg_y, seg_valid);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    chk_head("idle_tick_ignored", 6'd20, 5'd15);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL idle_left_ignored: running=%b expected 0", running);
    end
  endtask

  task automatic test_move();
    logic ate_seen;
    ate_seen = 1'b0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL start_run: running=%b expected 1", running);
    end
    tick(); ate_seen |= ate; chk_head("move1", 6'd21, 5'd15);
    tick(); ate_seen |= ate; chk_head("move2", 6'd22, 5'd15);
    tick(); ate_seen |= ate; chk_head("move3", 6'd23, 5'd15);
    seg_idx = 4'd2; #1;
    total++;
    if (seg_x !== 6'd21 || seg_y !== 5'd15 || length !== 5'd3 || ate_seen !== 1'b0) begin
      bad++; $display("FAIL move_seg2: seg2=(%0d,%0d) len=%0d ate_seen=%b expected (21,15) 3 0",
                      seg_x, seg_y, length, ate_seen);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) tick();
    chk_head("wrap_x_edge", 6'd39, 5'd15);
    tick();
    chk_head("wrap_x", 6'd0, 5'd15);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    chk_head("wrap_y_edge", 6'd0, 5'd0);
    tick();
    chk_head("wrap_y", 6'd0, 5'd29);
  endtask

  task automatic test_reversal();
    @(negedge clk) set_btn(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    chk_head("reverse_ignored", 6'd0, 5'd28);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_head("prio_left_over_right", 6'd39, 5'd28);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_head("reverse_right_ignored", 6'd38, 5'd28);
    @(negedge clk) begin set_btn(1'b1, 1'b1, 1'b0, 1'b0); update_clk = 1'b1; end
    @(negedge clk) begin set_btn(1'b0, 1'b0, 1'b0, 1'b0); update_clk = 1'b0; end
    chk_head("same_edge_btn_deferred", 6'd37, 5'd28);
    tick();
    chk_head("prio_up_over_down", 6'd37, 5'd27);
  endtask

  task automatic test_grow();
    food_x = 6'd37; food_y = 5'd26;
    tick();
    chk_head("grow_head", 6'd37, 5'd26);
    total++;
    if (ate !== 1'b1 || length !== 5'd4) begin
      bad++; $display("FAIL grow_ate: ate=%b len=%0d expected 1 4", ate, length);
    end
    @(negedge clk);
    total++;
    if (ate !== 1'b0) begin
      bad++; $display("FAIL ate_pulse_width: ate=%b expected 0", ate);
    end
    for (int k = 0; k < 12; k++) begin
      food_y = 5'(25 - k);
      tick();
    end
    seg_idx = 4'd15; #1;
    total++;
    if (length !== 5'd16 || seg_valid !== 1'b1 || seg_y !== 5'd28) begin
      bad++; $display("FAIL grow_full: len=%0d v=%b seg15_y=%0d expected 16 1 28",
                      length, seg_valid, seg_y);
    end
    food_y = 5'd13;
    tick();
    total++;
    if (ate !== 1'b1 || length !== 5'd16) begin
      bad++; $display("FAIL saturate: ate=%b len=%0d expected 1 16", ate, length);
    end
    chk_head("saturate_head", 6'd37, 5'd13);
    food_x = 6'd63; food_y = 5'd31;
  endtask

  task automatic test_collision();
    press(1'b0, 1'b0, 1'b0, 1'b1); tick(); chk_head("coll_right", 6'd38, 5'd13);
    press(1'b0, 1'b1, 1'b0, 1'b0); tick(); chk_head("coll_down", 6'd38, 5'd14);
    press(1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk_head("coll_head_frozen", 6'd38, 5'd14);
    total++;
    if (game_over !== 1'b1 || running !== 1'b0 || length !== 5'd16 || ate !== 1'b0) begin
      bad++; $display("FAIL collision: go=%b run=%b len=%0d ate=%b expected 1 0 16 0",
                      game_over, running, length, ate);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_head("dead_frozen", 6'd38, 5'd14);
    total++;
    if (game_over !== 1'b1) begin
      bad++; $display("FAIL dead_stays: game_over=%b expected 1", game_over);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_head("pre_reset_move", 6'd21, 5'd15);
    @(negedge clk) update_clk = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_head("async_reset_head", 6'd20, 5'd15);
    total++;
    if (running !== 1'b0 || game_over !== 1'b0 || length !== 5'd3) begin
      bad++; $display("FAIL async_reset: run=%b go=%b len=%0d expected 0 0 3",
                      running, game_over, length);
    end
    @(negedge clk) begin rst = 1'b0; update_clk = 1'b0; end
    tick(); tick();
    chk_head("reset_then_idle", 6'd20, 5'd15);
  endtask

  task automatic test_tail_chase();
    @(negedge clk) begin btn_right = 1'b1; update_clk = 1'b1; end
    @(negedge clk) begin btn_right = 1'b0; update_clk = 1'b0; end
    chk_head("idle_press_tick_ignored", 6'd20, 5'd15);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL idle_press_run: running=%b expected 1", running);
    end
    food_x = 6'd21; food_y = 5'd15;
    tick();
    food_x = 6'd63; food_y = 5'd31;
    press(1'b0, 1'b1, 1'b0, 1'b0); tick();
    press(1'b0, 1'b0, 1'b1, 1'b0); tick();
    press(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk_head("tail_chase_up", 6'd20, 5'd15);
    press(1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk_head("tail_chase_right", 6'd21, 5'd15);
    total++;
    if (game_over !== 1'b0 || length !== 5'd4) begin
      bad++; $display("FAIL tail_chase: go=%b len=%0d expected 0 4", game_over, length);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk) update_clk = 1'b1;
    @(negedge clk);
    @(negedge clk) update_clk = 1'b0;
    chk_head("back_to_back", 6'd23, 5'd15);
  endtask

  initial begin
    test_reset();
    test_move();
    test_wrap();
    test_reversal();
    test_grow();
    test_collision();
    test_reset_mid_run();
    test_tail_chase();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
